// File: rtl/enabled_register_file.sv
// Register bank with byte-enabled write port, two combinational read ports with
// optional same-cycle bypass, and a one-register-per-cycle bulk-clear sequencer.
module enabled_register_file #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned NUM_REGS  = 8,
   parameter int unsigned ZERO_REG0 = 1,
   parameter int unsigned BYPASS    = 1,
   localparam int unsigned ADDR_W   = $clog2(NUM_REGS),
   localparam int unsigned BE_W     = WIDTH / 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              writeEnable,
   input  logic [ADDR_W-1:0] writeAddr,
   input  logic [WIDTH-1:0]  writeData,
   input  logic [BE_W-1:0]   byteEnable,
   input  logic [ADDR_W-1:0] readAddrA,
   output logic [WIDTH-1:0]  readDataA,
   input  logic [ADDR_W-1:0] readAddrB,
   output logic [WIDTH-1:0]  readDataB,
   input  logic              clearReq,
   output logic              clearBusy,
   output logic              clearDone
);

   if ((WIDTH % 8) != 0 || WIDTH == 0) begin : g_bad_width
      $error("WIDTH must be a non-zero multiple of 8");
   end
   if (NUM_REGS < 2 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_depth
      $error("NUM_REGS must be a power of two and at least 2");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEARING,
      S_DONE
   } clr_state_e;

   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]  regs_q [NUM_REGS];
   logic [WIDTH-1:0]  regs_d [NUM_REGS];

   logic              wr_commit;
   logic [WIDTH-1:0]  wr_merged;

   // Clear sequencer: state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Clear sequencer: next state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (clearReq) begin
               state_d = S_CLEARING;
               cnt_d   = '0;
            end
         end
         S_CLEARING: begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Clear sequencer: outputs
   always_comb begin
      clearBusy = (state_q == S_CLEARING);
      clearDone = (state_q == S_DONE);
   end

   // Write qualification and byte merge against the stored word
   always_comb begin
      wr_commit = writeEnable && (state_q != S_CLEARING) && (|byteEnable)
                  && !((ZERO_REG0 != 0) && (writeAddr == '0));
      wr_merged = regs_q[writeAddr];
      for (int unsigned b = 0; b < BE_W; b++) begin
         if (byteEnable[b]) begin
            wr_merged[8*b +: 8] = writeData[8*b +: 8];
         end
      end
   end

   // Writes and the sweep never coincide: a commit requires state != CLEARING
   always_comb begin
      regs_d = regs_q;
      if (state_q == S_CLEARING) begin
         regs_d[cnt_q] = '0;
      end
      if (wr_commit) begin
         regs_d[writeAddr] = wr_merged;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] addr);
      logic [WIDTH-1:0] data;
      data = regs_q[addr];
      if ((BYPASS != 0) && wr_commit && (addr == writeAddr)) begin
         data = wr_merged;
      end
      if ((ZERO_REG0 != 0) && (addr == '0)) begin
         data = '0;
      end
      return data;
   endfunction

   always_comb begin
      readDataA = read_port(readAddrA);
      readDataB = read_port(readAddrB);
   end

endmodule
